// File: rtl/mips_cpu_mult_div_seq.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Retires BITS_PER_CYCLE bits per clock; MTHI/MTLO write HI/LO in a single cycle.
module mips_cpu_mult_div_seq #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q;
    logic              done_q, dz_q;
    logic [WIDTH-1:0]  hi_q, lo_q;
    logic [WIDTH-1:0]  acc_q, sr_q, opnd_q;
    logic              is_mult_q, is_signed_q, sign_a_q, sign_b_q;
    logic [WIDTH-1:0]  acc_n, sr_n;
    logic [WIDTH:0]    sum, rem;
    logic signed [2*WIDTH-1:0] prod_fix;
    logic signed [WIDTH-1:0]   quot_fix, rem_fix;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_if2(input logic [2*WIDTH-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start && !op[2]) state_d = S_ITER;
            S_ITER: begin
                if (cancel)                    state_d = S_IDLE;
                else if (cnt_q == CW'(N - 1))  state_d = S_FIX;
            end
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // One iteration: shift-add for multiply, restoring subtract for divide
    always_comb begin
        acc_n = acc_q;
        sr_n  = sr_q;
        sum   = '0;
        rem   = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (is_mult_q) begin
                sum   = {1'b0, acc_n} + {1'b0, (sr_n[0] ? opnd_q : '0)};
                acc_n = sum[WIDTH:1];
                sr_n  = {sum[0], sr_n[WIDTH-1:1]};
            end else begin
                rem  = {acc_n, sr_n[WIDTH-1]};
                sr_n = {sr_n[WIDTH-2:0], 1'b0};
                if (rem >= {1'b0, opnd_q}) begin
                    rem     = rem - {1'b0, opnd_q};
                    sr_n[0] = 1'b1;
                end
                acc_n = rem[WIDTH-1:0];
            end
        end
    end

    // Sign correction: quotient negated on sign mismatch, remainder follows the dividend
    always_comb begin
        prod_fix = neg_if2({acc_q, sr_q}, is_signed_q && (sign_a_q ^ sign_b_q));
        quot_fix = neg_if(sr_q, is_signed_q && (sign_a_q ^ sign_b_q));
        rem_fix  = neg_if(acc_q, is_signed_q && sign_a_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start && !op[2])           cnt_q <= '0;
                    else if (start && op == 3'b100) hi_q <= a;
                    else if (start && op == 3'b101) lo_q <= a;
                end
                S_ITER: if (!cancel) cnt_q <= cnt_q + CW'(1);
                S_FIX: begin
                    if (!cancel) begin
                        done_q <= 1'b1;
                        if (is_mult_q) begin
                            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_q <= prod_fix[WIDTH-1:0];
                        end else if (opnd_q == '0) begin
                            dz_q <= 1'b1;
                        end else begin
                            hi_q <= rem_fix;
                            lo_q <= quot_fix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && start && !op[2]) begin
            is_mult_q   <= op[0];
            is_signed_q <= op[1];
            sign_a_q    <= a[WIDTH-1];
            sign_b_q    <= b[WIDTH-1];
            acc_q       <= '0;
            sr_q        <= mag(a, op[1]);
            opnd_q      <= mag(b, op[1]);
        end else if (state_q == S_ITER) begin
            acc_q <= acc_n;
            sr_q  <= sr_n;
        end
    end
endmodule
